crash_course_cpu_program_loader_memory: RTL and testbench

Writable, parametrised program memory for the crash-course CPU. It replaces the fixed-ROM program store, and its combinational instruction read port is unchanged from the CPU's point of view. A byte-stream loader port (valid/ready) writes a new program at run time. While a load session is in progress, the block holds the CPU in reset.

---
 rtl/crash_course_cpu_program_loader_memory.sv | 148 ++++++++++++++
 tb/tb_crash_course_cpu_program_loader_memory.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crash_course_cpu_program_loader_memory.sv
// Writable program memory for the crash-course CPU: combinational instruction fetch
// plus a big-endian byte-stream loader that holds the CPU in reset while it runs.
module crash_course_cpu_program_loader_memory #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  program_counter,
    output logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   load_start,
    input  logic [ADDR_WIDTH-1:0]  load_word_count,
    input  logic                   load_abort,
    input  logic [7:0]             load_byte,
    input  logic                   load_byte_valid,
    output logic                   load_byte_ready,
    output logic                   cpu_hold,
    output logic                   load_done,
    output logic                   load_error
);

    localparam int BYTES_PER_WORD = INSTR_WIDTH / 8;
    localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        FINISH
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [INSTR_WIDTH-1:0]   mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0]    last_addr;
    logic [ADDR_WIDTH-1:0]    wr_addr;
    logic [IDX_W-1:0]         byte_idx;
    logic [INSTR_WIDTH-1:0]   word_buf;
    logic [INSTR_WIDTH-1:0]   next_word;
    logic                     error_q;

    logic start_ok;
    logic start_bad;
    logic byte_take;
    logic word_write;
    logic abort_rx;
    logic count_ok;
    logic pc_in_range;

    assign count_ok    = ({1'b0, load_word_count} < DEPTH_L);
    assign pc_in_range = ({1'b0, program_counter} < DEPTH_L);
    // Shifting in at the bottom leaves byte 0 in the top lane once the word is full.
    assign next_word   = (word_buf << 8) | INSTR_WIDTH'(load_byte);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        byte_take  = 1'b0;
        word_write = 1'b0;
        abort_rx   = 1'b0;
        case (state)
            IDLE: begin
                if (load_start && !load_abort) begin
                    if (count_ok) begin
                        start_ok   = 1'b1;
                        state_next = RECEIVE;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            RECEIVE: begin
                if (load_abort) begin
                    abort_rx   = 1'b1;
                    state_next = IDLE;
                end else if (load_byte_valid) begin
                    byte_take = 1'b1;
                    if (byte_idx == LAST_IDX) begin
                        word_write = 1'b1;
                        if (wr_addr == last_addr) begin
                            state_next = FINISH;
                        end
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the program store is cleared by reset, so the array lives inside the reset
    // branch; this rules out RAM-macro inference and keeps it as a register array.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr <= '0;
            wr_addr   <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            error_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            error_q <= start_bad | abort_rx;
            if (start_ok) begin
                last_addr <= load_word_count;
                wr_addr   <= '0;
                byte_idx  <= '0;
                word_buf  <= '0;
            end else if (abort_rx) begin
                byte_idx <= '0;
                word_buf <= '0;
            end else if (byte_take) begin
                word_buf <= next_word;
                if (word_write) begin
                    mem[wr_addr[MEM_AW-1:0]] <= next_word;
                    byte_idx <= '0;
                    if (wr_addr != last_addr) begin
                        wr_addr <= wr_addr + ADDR_WIDTH'(1);
                    end
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end
        end
    end

    assign load_byte_ready = (state == RECEIVE);
    assign cpu_hold        = (state != IDLE);
    assign load_done       = (state == FINISH);
    assign load_error      = error_q;

    assign instruction = (cpu_hold || !pc_in_range) ? '0 : mem[program_counter[MEM_AW-1:0]];

endmodule

// File: tb/tb_crash_course_cpu_program_loader_memory.sv
// Scoreboard bench for the program loader memory: stimulus queues expected pulses and
// probe values, a negedge monitor pops and compares whenever the DUT presents them.
module tb_crash_course_cpu_program_loader_memory;

    localparam int IW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] program_counter;
    logic [IW-1:0] instruction;
    logic          load_start;
    logic [AW-1:0] load_word_count;
    logic          load_abort;
    logic [7:0]    load_byte;
    logic          load_byte_valid;
    logic          load_byte_ready;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;

    crash_course_cpu_program_loader_memory #(
        .INSTR_WIDTH(IW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .program_counter(program_counter),
        .instruction    (instruction),
        .load_start     (load_start),
        .load_word_count(load_word_count),
        .load_abort     (load_abort),
        .load_byte      (load_byte),
        .load_byte_valid(load_byte_valid),
        .load_byte_ready(load_byte_ready),
        .cpu_hold       (cpu_hold),
        .load_done      (load_done),
        .load_error     (load_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {PR_READ, PR_STATUS} probe_kind_t;
    typedef struct {
        probe_kind_t   kind;
        string         name;
        logic [IW-1:0] value;
    } probe_t;

    probe_t probe_q[$];
    int     done_q[$];
    int     err_q[$];
    logic   probe_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IW-1:0] fib [12] = '{16'hA100, 16'hA200, 16'hA301, 16'h9001, 16'hB012, 16'h1123,
                                16'hC203, 16'h2210, 16'hD001, 16'h3321, 16'hF10A, 16'hE005};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: status word is {cpu_hold, load_byte_ready, load_done, load_error}.
    always @(negedge clk) begin
        if (load_done === 1'b1) begin
            if (done_q.size() == 0) check("no_done_pulse", 32'(load_done), 32'd0);
            else                    check("load_done_cycle", cyc, done_q.pop_front());
        end
        if (load_error === 1'b1) begin
            if (err_q.size() == 0) check("no_error_pulse", 32'(load_error), 32'd0);
            else                   check("load_error_cycle", cyc, err_q.pop_front());
        end
        if (probe_en && probe_q.size() > 0) begin
            probe_t p;
            p = probe_q.pop_front();
            if (p.kind == PR_READ) check(p.name, 32'(instruction), 32'(p.value));
            else check(p.name, {28'd0, cpu_hold, load_byte_ready, load_done, load_error}, 32'(p.value));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input probe_kind_t k, input string name, input logic [AW-1:0] pc,
                         input logic [IW-1:0] expected);
        probe_t p;
        p.kind  = k;
        p.name  = name;
        p.value = expected;
        program_counter = pc;
        probe_q.push_back(p);
        probe_en = 1'b1;
        tick();
        probe_en = 1'b0;
    endtask

    task automatic start_session(input int count, output int start_cyc);
        load_word_count = AW'(count);
        load_start      = 1'b1;
        tick();
        load_start = 1'b0;
        start_cyc  = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_byte       = b;
        load_byte_valid = 1'b1;
        tick();
        load_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [IW-1:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst             = 1'b1;
        program_counter = '0;
        load_start      = 1'b0;
        load_word_count = '0;
        load_abort      = 1'b0;
        load_byte       = '0;
        load_byte_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        probe(PR_STATUS, "reset_status", 8'h00, 16'h0000);
        probe(PR_READ,   "reset_pc00",   8'h00, 16'h0000);
        probe(PR_READ,   "reset_pc0f",   8'h0F, 16'h0000);

        // Start and abort together in IDLE: nothing happens
        load_word_count = 8'd2;
        load_start      = 1'b1;
        load_abort      = 1'b1;
        tick();
        load_start = 1'b0;
        load_abort = 1'b0;
        probe(PR_STATUS, "start_abort_idle",  8'h00, 16'h0000);
        probe(PR_STATUS, "start_abort_idle2", 8'h00, 16'h0000);

        // Oversize request with DEPTH=16
        start_session(16, s);
        err_q.push_back(s);
        probe(PR_STATUS, "oversize_err",   8'h00, 16'h0001);
        probe(PR_STATUS, "oversize_after", 8'h00, 16'h0000);
        probe(PR_READ,   "pc20_out_of_range", 8'h20, 16'h0000);

        // Fib load, no backpressure: 24 bytes, FINISH is 24 cycles after the first RECEIVE cycle
        start_session(11, s);
        done_q.push_back(s + 24);
        for (int i = 0; i < 12; i++) send_word(fib[i]);
        probe(PR_STATUS, "fib_finish", 8'h00, 16'h000A);
        probe(PR_STATUS, "fib_idle",   8'h00, 16'h0000);
        probe(PR_READ, "fib_pc00", 8'h00, 16'hA100);
        probe(PR_READ, "fib_pc05", 8'h05, 16'h1123);
        probe(PR_READ, "fib_pc0b", 8'h0B, 16'hE005);
        probe(PR_READ, "fib_pc0c", 8'h0C, 16'h0000);

        // Abort with the first byte of word 2; bytes at s..s+3, abort edge ends s+4
        start_session(3, s);
        send_word(16'h1111);
        send_word(16'h2222);
        err_q.push_back(s + 5);
        load_byte       = 8'h33;
        load_byte_valid = 1'b1;
        load_abort      = 1'b1;
        tick();
        load_byte_valid = 1'b0;
        load_abort      = 1'b0;
        probe(PR_STATUS, "abort_err",   8'h00, 16'h0001);
        probe(PR_STATUS, "abort_after", 8'h00, 16'h0000);
        probe(PR_READ, "abort_pc00", 8'h00, 16'h1111);
        probe(PR_READ, "abort_pc01", 8'h01, 16'h2222);
        probe(PR_READ, "abort_pc02", 8'h02, 16'hA301);
        probe(PR_READ, "abort_pc03", 8'h03, 16'h9001);

        // Backpressure: 3 idle cycles between the bytes of word 4
        start_session(11, s);
        done_q.push_back(s + 27);
        for (int i = 0; i < 4; i++) send_word(fib[i]);
        send_byte(fib[4][15:8]);
        load_byte = 8'hFF;
        probe(PR_STATUS, "gap_hold",        8'h00, 16'h000C);
        probe(PR_READ,   "gap_read_forced", 8'h00, 16'h0000);
        probe(PR_STATUS, "gap_hold2",       8'h00, 16'h000C);
        send_byte(fib[4][7:0]);
        for (int i = 5; i < 12; i++) send_word(fib[i]);
        probe(PR_STATUS, "bp_finish", 8'h00, 16'h000A);
        probe(PR_STATUS, "bp_idle",   8'h00, 16'h0000);
        for (int i = 0; i < 12; i++) probe(PR_READ, $sformatf("bp_pc%02h", i), AW'(i), fib[i]);

        // Reset after 5 of 8 bytes
        start_session(3, s);
        send_word(16'h5A5A);
        send_word(16'h6B6B);
        send_byte(8'h7C);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        probe(PR_STATUS, "rst_mid_status", 8'h00, 16'h0000);
        probe(PR_READ, "rst_mid_pc00", 8'h00, 16'h0000);
        probe(PR_READ, "rst_mid_pc05", 8'h05, 16'h0000);
        probe(PR_READ, "rst_mid_pc0b", 8'h0B, 16'h0000);

        // Fresh session after reset
        start_session(1, s);
        done_q.push_back(s + 4);
        send_word(16'hBEEF);
        send_word(16'h0042);
        probe(PR_STATUS, "fresh_finish", 8'h00, 16'h000A);
        probe(PR_READ, "fresh_pc00", 8'h00, 16'hBEEF);
        probe(PR_READ, "fresh_pc01", 8'h01, 16'h0042);
        probe(PR_READ, "fresh_pc02", 8'h02, 16'h0000);

        repeat (4) tick();
        check("pending_done",  done_q.size(),  0);
        check("pending_error", err_q.size(),   0);
        check("pending_probe", probe_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
